atm_session_initiator: RTL

- Customer-side transaction sequencer that drives the ATM controller's user interface: card, PIN, language, opcode, amount, deposit strobe, another-operation, eject.
- Takes one transaction request at a time from a host over a valid/ready handshake and sequences the ATM inputs.
- Waits for the ATM's completion flags, then returns status and balance on a valid/ready response channel.
- Sits between the host/keypad model and the ATM controller.

---
 rtl/atm_session_initiator.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/atm_session_initiator.sv
// atm_session_initiator
//   Customer-side transaction sequencer for the ATM controller. Accepts one
//   host request at a time (valid/ready), drives the ATM user inputs (card,
//   PIN, language, opcode, amount, deposit strobe, another-operation, eject),
//   waits for the ATM completion flags and returns status plus balance on a
//   valid/ready response channel. All outputs are registered.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   req_valid/req_ready         host request handshake
//   req_op/amount/pin/lang/more request fields (op 11 is reserved -> BADOP)
//   rsp_valid/rsp_ready         response handshake
//   rsp_status/rsp_balance      0 OK, 1 BADPIN, 2 TIMEOUT, 3 ABORT, 4 BADOP
//   cardIn ... Another_Operation  drives to the ATM controller
//   correctPassword ... Current_Balance  flags/data from the ATM controller
module atm_session_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_amount,
  input  logic [3:0]  req_pin,
  input  logic        req_lang,
  input  logic        req_more,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [31:0] rsp_balance,
  output logic        cardIn,
  output logic        ejectCard,
  output logic [3:0]  password,
  output logic        Language,
  output logic [1:0]  opCode,
  output logic [6:0]  inputAmount,
  output logic        moneyDeposited,
  output logic        Another_Operation,
  input  logic        correctPassword,
  input  logic        Balance_Shown,
  input  logic        Deposited_Successfully,
  input  logic        Withdrawed_Successfully,
  input  logic        ATM_Usage_Finished,
  input  logic [31:0] Current_Balance
);

  typedef enum logic [2:0] {
    S_IDLE, S_INSERT, S_AUTH, S_SELECT, S_EXEC, S_RESULT, S_EJECT
  } state_t;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_BADPIN  = 3'd1;
  localparam logic [2:0] ST_TIMEOUT = 3'd2;
  localparam logic [2:0] ST_ABORT   = 3'd3;
  localparam logic [2:0] ST_BADOP   = 3'd4;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              session_q, session_d;
  // Set when the ATM reported end-of-usage during this transaction, so a
  // "more" request cannot keep a session the ATM has already closed.
  logic              closed_q, closed_d;
  logic [1:0]        op_q, op_d;
  logic [6:0]        amount_q, amount_d;
  logic              more_q, more_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        status_q, status_d;
  logic [31:0]       balance_q, balance_d;
  logic              card_q, card_d;
  logic              eject_q, eject_d;
  logic [3:0]        pwd_q, pwd_d;
  logic              lang_q, lang_d;
  logic [1:0]        opc_q, opc_d;
  logic [6:0]        amt_o_q, amt_o_d;
  logic              dep_q, dep_d;
  logic              another_q, another_d;

  logic              timeout;
  logic              done_flag;
  logic              go_select;
  logic [1:0]        sel_op;
  logic [6:0]        sel_amount;

  always_comb begin
    state_d     = state_q;
    session_d   = session_q;
    closed_d    = closed_q;
    op_d        = op_q;
    amount_d    = amount_q;
    more_d      = more_q;
    status_d    = status_q;
    balance_d   = balance_q;
    card_d      = card_q;
    eject_d     = eject_q;
    pwd_d       = pwd_q;
    lang_d      = lang_q;
    opc_d       = opc_q;
    amt_o_d     = amt_o_q;
    dep_d       = 1'b0;
    another_d   = 1'b0;
    go_select   = 1'b0;
    sel_op      = op_q;
    sel_amount  = amount_q;
    timeout     = (timer_q == TMO_LAST);

    case (op_q)
      2'b00:   done_flag = Balance_Shown;
      2'b01:   done_flag = Deposited_Successfully;
      2'b10:   done_flag = Withdrawed_Successfully;
      default: done_flag = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d     = req_op;
          amount_d = req_amount;
          more_d   = req_more;
          closed_d = 1'b0;
          if (req_op == 2'b11) begin
            status_d = ST_BADOP;
            state_d  = S_RESULT;
          end else if (session_q) begin
            go_select  = 1'b1;
            sel_op     = req_op;
            sel_amount = req_amount;
          end else begin
            card_d  = 1'b1;
            pwd_d   = req_pin;
            lang_d  = req_lang;
            state_d = S_INSERT;
          end
        end
      end
      S_INSERT: state_d = S_AUTH;
      S_AUTH: begin
        if (correctPassword) begin
          go_select = 1'b1;
        end else if (timeout) begin
          status_d = ST_BADPIN;
          state_d  = S_RESULT;
        end
      end
      S_SELECT: state_d = S_EXEC;
      S_EXEC: begin
        if (done_flag) begin
          balance_d = Current_Balance;
          status_d  = ST_OK;
          state_d   = S_RESULT;
          if (ATM_Usage_Finished) begin
            session_d = 1'b0;
            closed_d  = 1'b1;
          end
        end else if (ATM_Usage_Finished) begin
          status_d  = ST_ABORT;
          session_d = 1'b0;
          closed_d  = 1'b1;
          state_d   = S_RESULT;
        end else if (timeout) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESULT;
        end
      end
      S_RESULT: begin
        if (rsp_ready && rsp_valid_q) begin
          if (status_q == ST_OK && more_q && !closed_q) begin
            another_d = 1'b1;
            session_d = 1'b1;
            state_d   = S_IDLE;
          end else if (status_q == ST_BADOP) begin
            state_d = S_IDLE;
          end else begin
            card_d  = 1'b0;
            eject_d = 1'b1;
            state_d = S_EJECT;
          end
        end
      end
      S_EJECT: begin
        if (ATM_Usage_Finished || timeout) begin
          eject_d   = 1'b0;
          session_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Opcode/amount are presented on entry to SELECT so they are already
    // valid at the ATM during the single SELECT cycle.
    if (go_select) begin
      opc_d   = sel_op;
      amt_o_d = (sel_op == 2'b00) ? 7'd0 : sel_amount;
      dep_d   = (sel_op == 2'b01);
      state_d = S_SELECT;
    end

    if (state_d != state_q)    timer_d = '0;
    else if (timer_q == CNT_MAX) timer_d = timer_q;
    else                         timer_d = timer_q + CNT_W'(1);

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      session_q   <= 1'b0;
      closed_q    <= 1'b0;
      op_q        <= '0;
      amount_q    <= '0;
      more_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      status_q    <= '0;
      balance_q   <= '0;
      card_q      <= 1'b0;
      eject_q     <= 1'b0;
      pwd_q       <= '0;
      lang_q      <= 1'b0;
      opc_q       <= '0;
      amt_o_q     <= '0;
      dep_q       <= 1'b0;
      another_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      session_q   <= session_d;
      closed_q    <= closed_d;
      op_q        <= op_d;
      amount_q    <= amount_d;
      more_q      <= more_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      balance_q   <= balance_d;
      card_q      <= card_d;
      eject_q     <= eject_d;
      pwd_q       <= pwd_d;
      lang_q      <= lang_d;
      opc_q       <= opc_d;
      amt_o_q     <= amt_o_d;
      dep_q       <= dep_d;
      another_q   <= another_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_status        = status_q;
  assign rsp_balance       = balance_q;
  assign cardIn            = card_q;
  assign ejectCard         = eject_q;
  assign password          = pwd_q;
  assign Language          = lang_q;
  assign opCode            = opc_q;
  assign inputAmount       = amt_o_q;
  assign moneyDeposited    = dep_q;
  assign Another_Operation = another_q;

endmodule
